pacoblaze_alu_seq: RTL and testbench

//  Execute stage downstream of the PacoBlaze register file. Takes sX/sY operands read from the

---
 rtl/pacoblaze_alu_seq.sv | 254 +++++++++++++++++++++++++
 tb/tb_pacoblaze_alu_seq.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pacoblaze_alu_seq.sv
// PacoBlaze execute stage: ALU, C/Z flags with interrupt shadow,
// iterative shift-add MUL, and register file write-back sequencing.
module pacoblaze_alu_seq #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [3:0]       op_code,
    input  logic [DEPTH-1:0] op_x_addr,
    input  logic [DEPTH-1:0] op_y_addr,
    input  logic [WIDTH-1:0] operand_x,
    input  logic [WIDTH-1:0] operand_y,
    input  logic             flag_save,
    input  logic             flag_restore,
    output logic             wb_write_enable,
    output logic [DEPTH-1:0] wb_address,
    output logic [WIDTH-1:0] wb_data,
    output logic             carry,
    output logic             zero,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WB,
        S_MUL,
        S_WB_LO,
        S_WB_HI
    } state_t;

    state_t             state_q, state_d;
    logic               we_q, we_d;
    logic [DEPTH-1:0]   addr_q, addr_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               c_q, c_d;
    logic               z_q, z_d;
    logic               sc_q, sc_d;
    logic               sz_q, sz_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [DEPTH-1:0]   xa_q, xa_d;
    logic [DEPTH-1:0]   ya_q, ya_d;

    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   res;
    logic               alu_c;
    logic               alu_we;
    logic               alu_fl;
    logic [2*WIDTH-1:0] prod_n;
    logic               upd;
    logic               upd_c;
    logic               upd_z;

    // Combinational ALU on the raw operands; only used in the accept cycle.
    always_comb begin
        sum    = '0;
        res    = '0;
        alu_c  = c_q;
        alu_we = 1'b1;
        alu_fl = 1'b1;
        case (op_code)
            4'h0: begin
                res    = operand_y;
                alu_fl = 1'b0;
            end
            4'h1: begin
                res   = operand_x & operand_y;
                alu_c = 1'b0;
            end
            4'h2: begin
                res   = operand_x | operand_y;
                alu_c = 1'b0;
            end
            4'h3: begin
                res   = operand_x ^ operand_y;
                alu_c = 1'b0;
            end
            4'h4, 4'h5: begin
                sum = {1'b0, operand_x} + {1'b0, operand_y}
                    + {{WIDTH{1'b0}}, (op_code[0] & c_q)};
                res   = sum[WIDTH-1:0];
                alu_c = sum[WIDTH];
            end
            4'h6, 4'h7, 4'h8: begin
                sum = {1'b0, operand_x} - {1'b0, operand_y}
                    - {{WIDTH{1'b0}}, (op_code == 4'h7) & c_q};
                res    = sum[WIDTH-1:0];
                alu_c  = sum[WIDTH];
                alu_we = (op_code != 4'h8);
            end
            4'h9: begin
                res    = operand_x & operand_y;
                alu_c  = ^res;
                alu_we = 1'b0;
            end
            4'hA: begin
                res   = {1'b0, operand_x[WIDTH-1:1]};
                alu_c = operand_x[0];
            end
            4'hB: begin
                res   = {operand_x[WIDTH-2:0], 1'b0};
                alu_c = operand_x[WIDTH-1];
            end
            4'hC: begin
                res   = {operand_x[0], operand_x[WIDTH-1:1]};
                alu_c = operand_x[0];
            end
            4'hD: begin
                res   = {operand_x[WIDTH-2:0], operand_x[WIDTH-1]};
                alu_c = operand_x[WIDTH-1];
            end
            default: begin
                alu_we = 1'b0;
                alu_fl = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        xa_d     = xa_q;
        ya_d     = ya_q;
        upd      = 1'b0;
        upd_c    = c_q;
        upd_z    = z_q;
        prod_n   = prod_q + (mplier_q[0] ? mcand_q : '0);
        case (state_q)
            S_IDLE: begin
                if (op_valid) begin
                    if (op_code == 4'hE) begin
                        state_d  = S_MUL;
                        mcand_d  = {{WIDTH{1'b0}}, operand_x};
                        mplier_d = operand_y;
                        prod_d   = '0;
                        cnt_d    = '0;
                        xa_d     = op_x_addr;
                        ya_d     = op_y_addr;
                    end else begin
                        state_d = S_WB;
                        if (alu_we) begin
                            we_d   = 1'b1;
                            addr_d = op_x_addr;
                            data_d = res;
                        end
                        upd   = alu_fl;
                        upd_c = alu_c;
                        upd_z = (res == '0);
                    end
                end
            end
            S_WB: state_d = S_IDLE;
            S_MUL: begin
                prod_d   = prod_n;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_WB_LO;
                    we_d    = 1'b1;
                    addr_d  = xa_q;
                    data_d  = prod_n[WIDTH-1:0];
                    upd     = 1'b1;
                    upd_c   = |prod_n[2*WIDTH-1:WIDTH];
                    upd_z   = (prod_n == '0);
                end
            end
            S_WB_LO: begin
                state_d = S_WB_HI;
                we_d    = 1'b1;
                addr_d  = ya_q;
                data_d  = prod_q[2*WIDTH-1:WIDTH];
            end
            S_WB_HI: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Restore beats ALU update; save samples pre-update flags, so both at once swap.
    always_comb begin
        c_d  = c_q;
        z_d  = z_q;
        sc_d = sc_q;
        sz_d = sz_q;
        if (flag_restore) begin
            c_d = sc_q;
            z_d = sz_q;
        end else if (upd) begin
            c_d = upd_c;
            z_d = upd_z;
        end
        if (flag_save) begin
            sc_d = c_q;
            sz_d = z_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            c_q      <= 1'b0;
            z_q      <= 1'b0;
            sc_q     <= 1'b0;
            sz_q     <= 1'b0;
            mcand_q  <= '0;
            prod_q   <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            xa_q     <= '0;
            ya_q     <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            c_q      <= c_d;
            z_q      <= z_d;
            sc_q     <= sc_d;
            sz_q     <= sz_d;
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            xa_q     <= xa_d;
            ya_q     <= ya_d;
        end
    end

    assign op_ready        = (state_q == S_IDLE);
    assign busy            = ~op_ready;
    assign wb_write_enable = we_q;
    assign wb_address      = addr_q;
    assign wb_data         = data_q;
    assign carry           = c_q;
    assign zero            = z_q;

endmodule

// File: tb/tb_pacoblaze_alu_seq.sv
// Directed bench for pacoblaze_alu_seq; expected writes go through a
// scoreboard queue checked by a write-back monitor.
module tb_pacoblaze_alu_seq;

    typedef struct packed {
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       op_valid = 1'b0;
    logic       op_ready;
    logic [3:0] op_code = '0;
    logic [3:0] op_x_addr = '0;
    logic [3:0] op_y_addr = '0;
    logic [7:0] operand_x = '0;
    logic [7:0] operand_y = '0;
    logic       flag_save = 1'b0;
    logic       flag_restore = 1'b0;
    logic       wb_write_enable;
    logic [3:0] wb_address;
    logic [7:0] wb_data;
    logic       carry;
    logic       zero;
    logic       busy;

    int  checks = 0;
    int  fails = 0;
    wr_t sb[$];

    pacoblaze_alu_seq #(.WIDTH(8), .DEPTH(4)) dut (
        .clk(clk),
        .reset(reset),
        .op_valid(op_valid),
        .op_ready(op_ready),
        .op_code(op_code),
        .op_x_addr(op_x_addr),
        .op_y_addr(op_y_addr),
        .operand_x(operand_x),
        .operand_y(operand_y),
        .flag_save(flag_save),
        .flag_restore(flag_restore),
        .wb_write_enable(wb_write_enable),
        .wb_address(wb_address),
        .wb_data(wb_data),
        .carry(carry),
        .zero(zero),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] a, input logic [7:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        sb.push_back(e);
    endtask

    task automatic flags(input logic [1:0] exp_cz, input string tag);
        chk({tag, "_C"}, 16'(carry), 16'(exp_cz[1]));
        chk({tag, "_Z"}, 16'(zero), 16'(exp_cz[0]));
    endtask

    always @(negedge clk) begin : mon
        wr_t e;
        if (!reset && wb_write_enable) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", {4'h0, wb_address, wb_data}, 16'hFFFF);
            end else begin
                e = sb.pop_front();
                chk("wb_addr", 16'(wb_address), 16'(e.a));
                chk("wb_data", 16'(wb_data), 16'(e.d));
            end
        end
    end

    // Issue one op; returns just after the accepting edge.
    task automatic op(input logic [3:0] c, input logic [3:0] xa,
                      input logic [3:0] ya, input logic [7:0] x,
                      input logic [7:0] y);
        int n = 0;
        @(negedge clk);
        while (!op_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("ready_timeout", 16'(op_ready), 16'h1);
        op_valid  = 1'b1;
        op_code   = c;
        op_x_addr = xa;
        op_y_addr = ya;
        operand_x = x;
        operand_y = y;
        @(posedge clk);
        #1;
        op_valid  = 1'b0;
        operand_x = 8'h5C;
        operand_y = 8'hC5;
    endtask

    // Single-cycle op, then check flags in the WB cycle.
    task automatic sop(input logic [3:0] c, input logic [3:0] xa,
                       input logic [7:0] x, input logic [7:0] y,
                       input logic [1:0] cz, input string tag);
        op(c, xa, 4'h0, x, y);
        @(negedge clk);
        flags(cz, tag);
    endtask

    // Count MUL busy cycles up to the first write; pokes op_valid meanwhile.
    task automatic mul_wait(output int bc);
        int n = 0;
        bc = 0;
        @(negedge clk);
        while (!wb_write_enable && n < 40) begin
            if (busy) bc++;
            if (n == 2) begin
                op_valid  = 1'b1;
                op_code   = 4'h0;
                op_x_addr = 4'hF;
                operand_y = 8'hEE;
            end
            if (n == 4) op_valid = 1'b0;
            @(negedge clk);
            n++;
        end
        op_valid = 1'b0;
    endtask

    task automatic strobe(input logic s, input logic r);
        @(negedge clk);
        flag_save    = s;
        flag_restore = r;
        @(posedge clk);
        #1;
        flag_save    = 1'b0;
        flag_restore = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int bc;
        repeat (2) @(negedge clk);
        chk("rst_ready", 16'(op_ready), 16'h1);
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_we", 16'(wb_write_enable), 16'h0);
        chk("rst_addr", 16'(wb_address), 16'h0);
        chk("rst_data", 16'(wb_data), 16'h0);
        flags(2'b00, "rst");
        reset = 1'b0;

        push(4'h5, 8'h10);
        op(4'h4, 4'h5, 4'h0, 8'hF0, 8'h20);
        @(negedge clk);
        chk("add_ready_low", 16'(op_ready), 16'h0);
        chk("add_busy", 16'(busy), 16'h1);
        chk("add_we", 16'(wb_write_enable), 16'h1);
        flags(2'b10, "add");
        @(negedge clk);
        chk("add_ready_back", 16'(op_ready), 16'h1);
        chk("add_we_off", 16'(wb_write_enable), 16'h0);
        chk("hold_addr", 16'(wb_address), 16'h5);
        chk("hold_data", 16'(wb_data), 16'h10);

        push(4'h6, 8'hFF);
        sop(4'h7, 4'h6, 8'h05, 8'h05, 2'b10, "subcy");
        op(4'h8, 4'h9, 4'h0, 8'h05, 8'h05);
        @(negedge clk);
        chk("cmp_we", 16'(wb_write_enable), 16'h0);
        flags(2'b01, "cmp");
        chk("cmp_hold_addr", 16'(wb_address), 16'h6);

        push(4'h1, 8'h30);
        sop(4'h1, 4'h1, 8'hF0, 8'h3C, 2'b00, "and");
        push(4'h2, 8'h00);
        sop(4'h3, 4'h2, 8'hAA, 8'hAA, 2'b01, "xor");
        push(4'h3, 8'hF5);
        sop(4'h2, 4'h3, 8'hF0, 8'h05, 2'b00, "or");
        sop(4'h9, 4'h4, 8'h07, 8'h03, 2'b00, "test_even");
        sop(4'h9, 4'h4, 8'h07, 8'h01, 2'b10, "test_odd");
        sop(4'h9, 4'h4, 8'hF0, 8'h0F, 2'b01, "test_zero");
        push(4'h4, 8'h40);
        sop(4'hA, 4'h4, 8'h81, 8'h00, 2'b10, "sr0");
        push(4'h4, 8'h02);
        sop(4'hB, 4'h4, 8'h81, 8'h00, 2'b10, "sl0");
        push(4'h4, 8'h80);
        sop(4'hC, 4'h4, 8'h01, 8'h00, 2'b10, "rr");
        push(4'h4, 8'h01);
        sop(4'hD, 4'h4, 8'h80, 8'h00, 2'b10, "rl");
        push(4'h4, 8'h00);
        sop(4'hA, 4'h4, 8'h01, 8'h00, 2'b11, "sr0_zero");
        push(4'hA, 8'h5A);
        sop(4'h0, 4'hA, 8'h00, 8'h5A, 2'b11, "load");
        sop(4'hF, 4'hB, 8'h00, 8'h00, 2'b11, "reserved");
        push(4'hC, 8'hF0);
        sop(4'h6, 4'hC, 8'h10, 8'h20, 2'b10, "sub");
        push(4'hD, 8'h03);
        sop(4'h5, 4'hD, 8'h01, 8'h01, 2'b00, "addcy");
        push(4'hE, 8'h00);
        sop(4'h4, 4'hE, 8'hFF, 8'h01, 2'b11, "add_wrap");

        push(4'h2, 8'hA8);
        push(4'h3, 8'h03);
        op(4'hE, 4'h2, 4'h3, 8'h12, 8'h34);
        mul_wait(bc);
        chk("mul_busy_cycles", 16'(bc), 16'd8);
        flags(2'b10, "mul");
        @(negedge clk);
        chk("mul_hi_we", 16'(wb_write_enable), 16'h1);
        @(negedge clk);
        chk("mul_done_ready", 16'(op_ready), 16'h1);

        push(4'h4, 8'h00);
        push(4'h4, 8'h00);
        op(4'hE, 4'h4, 4'h4, 8'h00, 8'h7F);
        mul_wait(bc);
        chk("mul0_busy_cycles", 16'(bc), 16'd8);
        flags(2'b01, "mul0");
        repeat (2) @(negedge clk);

        push(4'h7, 8'h00);
        push(4'h7, 8'h01);
        op(4'hE, 4'h7, 4'h7, 8'h10, 8'h10);
        mul_wait(bc);
        flags(2'b10, "mul_same");
        repeat (2) @(negedge clk);
        chk("mul_same_final", {4'h0, wb_address, wb_data}, 16'h0701);

        push(4'h1, 8'h10);
        sop(4'h4, 4'h1, 8'hF0, 8'h20, 2'b10, "pre_save");
        strobe(1'b1, 1'b0);
        flags(2'b10, "save");
        push(4'h1, 8'h00);
        sop(4'h4, 4'h1, 8'h00, 8'h00, 2'b01, "post_save_add");
        strobe(1'b0, 1'b1);
        flags(2'b10, "restore");
        push(4'h1, 8'h00);
        sop(4'h4, 4'h1, 8'h00, 8'h00, 2'b01, "pre_swap");
        strobe(1'b1, 1'b1);
        flags(2'b10, "swap");
        strobe(1'b0, 1'b1);
        flags(2'b01, "swap_shadow");

        op(4'hE, 4'h8, 4'h9, 8'hFF, 8'hFF);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_we", 16'(wb_write_enable), 16'h0);
        chk("midrst_ready", 16'(op_ready), 16'h1);
        flags(2'b00, "midrst");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        chk("post_rst_ready", 16'(op_ready), 16'h1);
        strobe(1'b0, 1'b1);
        flags(2'b00, "rst_shadow");
        chk("sb_empty", 16'(sb.size()), 16'h0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
